// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} mult_state_t;

  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ripple_add.sv
// Combinational W-bit ripple-carry adder; carry-out is returned as s[W].
module ripple_add #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   s
);

  logic [W-1:0] c;

  assign s[0] = x[0] ^ y[0];
  assign c[0] = x[0] & y[0];

  for (genvar i = 1; i < W; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ c[i-1];
    assign c[i] = (x[i] & y[i]) | (c[i-1] & (x[i] ^ y[i]));
  end

  assign s[W] = c[W-1];

endmodule

// File: rtl/shift_add_mult.sv
// Multi-cycle right-shift multiplier: one partial-product step per clock,
// sign handled by magnitude multiply plus final conditional negation.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int unsigned CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  mult_state_t   state;
  logic [W-1:0]  hi, lo, mc;
  logic [CW-1:0] cnt;
  logic          neg;
  logic [W-1:0]  mag_a, mag_b, addend;
  logic [W:0]    sum;

  assign mag_a = (signed_mode && a[W-1]) ? -a : a;
  assign mag_b = (signed_mode && b[W-1]) ? -b : b;

  // Gating the addend gives {0, hi} when lo[0] is clear, same as a result mux.
  assign addend = lo[0] ? mc : '0;

  ripple_add #(.W(W)) u_add (
    .x(hi),
    .y(addend),
    .s(sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mc    <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mc    <= mag_a;
            lo    <= mag_b;
            neg   <= signed_mode & (a[W-1] ^ b[W-1]);
            hi    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          hi  <= sum[W:1];
          lo  <= {sum[0], lo[W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          p     <= neg ? -{hi, lo} : {hi, lo};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at W=32 and W=8.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic        start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [63:0] p32;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic [63:0] q32_p[$];
  int unsigned q32_c[$];
  logic [15:0] q8_p[$];
  int unsigned q8_c[$];

  shift_add_mult #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .p(p32)
  );

  shift_add_mult #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop on every done pulse, compare product and completion cycle.
  initial begin
    logic [63:0] ep;
    int unsigned ec;
    forever begin
      @(negedge clk);
      if (done32 === 1'b1) begin
        if (q32_p.size() == 0) begin
          chk("w32 spurious done", 64'd1, 64'd0);
        end else begin
          ep = q32_p.pop_front();
          ec = q32_c.pop_front();
          chk("w32 product", p32, ep);
          chk("w32 latency", 64'(cyc), 64'(ec));
        end
        @(negedge clk);
        chk("w32 done one cycle", 64'(done32), 64'd0);
      end
    end
  end

  initial begin
    logic [15:0] ep;
    int unsigned ec;
    forever begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        if (q8_p.size() == 0) begin
          chk("w8 spurious done", 64'd1, 64'd0);
        end else begin
          ep = q8_p.pop_front();
          ec = q8_c.pop_front();
          chk("w8 product", 64'(p8), 64'(ep));
          chk("w8 latency", 64'(cyc), 64'(ec));
        end
      end
    end
  end

  task automatic go32(input logic sm, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [63:0] exp, input bit push);
    @(negedge clk);
    start32 = 1'b1; sm32 = sm; a32 = aa; b32 = bb;
    @(posedge clk); #1;
    if (push) begin
      q32_p.push_back(exp);
      q32_c.push_back(cyc + 33);
    end
    start32 = 1'b0;
  endtask

  task automatic drain32();
    int unsigned n = 0;
    while (q32_p.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("w32 drain timeout", 64'(q32_p.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned nbusy;
    bit          seen;

    repeat (3) @(negedge clk);
    chk("reset busy32", 64'(busy32), 64'd0);
    chk("reset done32", 64'(done32), 64'd0);
    chk("reset p32", p32, 64'd0);
    chk("reset p8", 64'(p8), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unsigned all-ones, with busy duration.
    go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy32) nbusy++;
      else break;
    end
    chk("busy cycles", 64'(nbusy), 64'd33);
    drain32();

    go32(1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    drain32();
    go32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    drain32();
    go32(1'b1, 32'h0, 32'h8000_0000, 64'h0, 1'b1);
    drain32();

    // Start held high through RUN with changing operands.
    @(negedge clk);
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    q32_p.push_back(64'h0B00_EA4E_242D_2080);
    q32_c.push_back(cyc + 33);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; sm32 = ~sm32;
    end
    start32 = 1'b0;
    drain32();

    // Back-to-back: second start issued in the done cycle.
    go32(1'b0, 32'd100, 32'd1000, 64'd100000, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done32) begin seen = 1'b1; break; end
    end
    chk("b2b first done seen", 64'(seen), 64'd1);
    start32 = 1'b1; sm32 = 1'b0; a32 = 32'd7; b32 = 32'd6;
    @(posedge clk); #1;
    q32_p.push_back(64'd42);
    q32_c.push_back(cyc + 33);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b p held", p32, 64'd100000);
    chk("b2b busy", 64'(busy32), 64'd1);
    drain32();

    // Reset during iteration 10.
    go32(1'b0, 32'hFFFF, 32'hFFFF, 64'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy32), 64'd0);
    chk("abort done", 64'(done32), 64'd0);
    chk("abort p", p32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("after abort p", p32, 64'd0);

    // W=8 signed boundary.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'h80; b8 = 8'h7F;
    @(posedge clk); #1;
    q8_p.push_back(16'hC080);
    q8_c.push_back(cyc + 9);
    start8 = 1'b0;
    repeat (15) @(negedge clk);
    chk("w8 drained", 64'(q8_p.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
